fft11_out_serializer: RTL
=========================

FFT11_OUT_SERIALIZER -- requirements
Module: fft11_out_serializer

Interface
REQ-001 The block SHALL have parameter WL_out, default 34, giving the width of each real or imaginary output component.
REQ-002 The block SHALL fix the point count at 11; this is not a parameter.
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 reset  input  1  Asynchronous, active-high reset.
REQ-005 in_valid  input  1  Frame strobe; connected to the FFT core's valid output.
REQ-006 in_data  input  22*WL_out  One packed frame {X0_r,X0_i,X1_r,X1_i,...,X10_r,X10_i}, with X0_r in the MSBs.
REQ-007 in_ready  output  1  Frame buffer can accept a frame this cycle.
REQ-008 out_valid  output  1  A bin is presented on out_r, out_i and out_idx.
REQ-009 out_ready  input  1  Downstream accepts the presented bin.
REQ-010 out_r  output  WL_out  Real part of the current bin, signed.
REQ-011 out_i  output  WL_out  Imaginary part of the current bin, signed.
REQ-012 out_idx  output  4  Bin index of the current beat, range 0..10.
REQ-013 out_last  output  1  High on the beat with out_idx == 10.
REQ-014 drop_cnt  output  8  Saturating count of frames discarded because the buffer was full.

Function
REQ-015 The block SHALL hold a two-entry frame FIFO with write pointer, read pointer and a 2-bit occupancy count (0..2).
REQ-016 in_ready SHALL equal (count < 2), derived from registered state only, with no combinational path from out_ready.
REQ-017 A frame SHALL be written on a rising edge where in_valid && in_ready, and count SHALL increment unless a pop occurs in the same cycle.
REQ-018 When in_valid && !in_ready, the frame SHALL be discarded and drop_cnt SHALL increment, saturating at 255.
REQ-019 out_valid SHALL equal (count != 0).
REQ-020 out_r and out_i SHALL carry bin out_idx of the head frame, and SHALL be 0 when out_valid == 0.
REQ-021 Bin k real part SHALL be taken from in_data[(22-2k)*WL_out-1 -: WL_out]; bin k imaginary part SHALL be the adjacent lower WL_out field.
REQ-022 A beat SHALL transfer on a rising edge where out_valid && out_ready; out_idx SHALL then increment by 1.
REQ-023 On a transfer with out_idx == 10, out_idx SHALL wrap to 0, the read pointer SHALL toggle, and the head frame SHALL be popped.
REQ-024 While out_valid && !out_ready, out_r, out_i, out_idx and out_last SHALL hold stable.
REQ-025 Latency: a frame written at edge N SHALL present bin 0 in the cycle after edge N if the FIFO was empty.
REQ-026 Simultaneous push and pop at count == 1 SHALL leave count at 1, and the new frame SHALL follow immediately after bin 10 with no bubble.
REQ-027 At count == 2 with a pop in the same cycle, in_ready SHALL still be 0, and an incoming frame SHALL be dropped and counted.
REQ-028 Frames SHALL be emitted in arrival order, with no reordering and no duplication.
REQ-029 Sustained throughput SHALL be 1 bin per cycle while out_ready == 1.

Reset
REQ-030 While reset == 1, the block SHALL asynchronously force: count=0, both pointers=0, out_idx=0, drop_cnt=0, out_valid=0, out_last=0, out_r=out_i=0, in_ready=1.
REQ-031 Assertion of reset mid-frame SHALL discard all buffered and partially sent frames; the first post-reset frame SHALL start at bin 0.
REQ-032 Sampling SHALL resume on the first rising edge after reset deasserts.

Verification
REQ-033 Single frame with X_k_r = k and X_k_i = -k, out_ready held 1 -> 11 consecutive beats, out_idx 0..10, out_r = 0..10, out_i = 0..-10, out_last only on beat 10, out_valid low afterwards.
REQ-034 Three frames on consecutive cycles into an empty FIFO, out_ready=1 -> frames 1 and 2 emitted, in_ready=0 on the 3rd cycle, frame 3 dropped, drop_cnt=1.
REQ-035 Two frames buffered, out_ready toggled 1/0 every cycle -> data held stable during stalls, 22 beats in order, no loss.
REQ-036 Push a new frame in the cycle of the bin-10 transfer at count=1 -> the next cycle shows bin 0 of the new frame, count stays 1.
REQ-037 300 frames offered with out_ready=0 -> exactly 2 frames stored, drop_cnt saturates at 255.
REQ-038 Assert reset for half a cycle during beat 5 -> all outputs go to their reset values immediately; the next frame starts at out_idx=0 with drop_cnt=0.

Source files
------------

// File: rtl/fft11_out_serializer.sv
// Two-frame buffer that streams an 11-point FFT result one bin per beat.
// A frame is popped after its bin 10 transfers; frames that arrive while the buffer is full are dropped and counted.
module fft11_out_serializer #(
  parameter int WL_out = 34
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [22*WL_out-1:0]  in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WL_out-1:0]     out_r,
  output logic [WL_out-1:0]     out_i,
  output logic [3:0]            out_idx,
  output logic                  out_last,
  output logic [7:0]            drop_cnt
);

  localparam int FW = 22 * WL_out;
  localparam logic [3:0] LAST_IDX = 4'd10;

  logic [FW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [3:0]    idx;
  logic [7:0]    drops;
  logic          push;
  logic          beat;
  logic          pop;
  logic          drop;
  logic [FW-1:0] head;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_idx   = idx;
  assign out_last  = out_valid && (idx == LAST_IDX);
  assign drop_cnt  = drops;

  assign push = in_valid && in_ready;
  assign drop = in_valid && !in_ready;
  assign beat = out_valid && out_ready;
  assign pop  = beat && (idx == LAST_IDX);
  assign head = mem[rd_ptr];

  // Payload storage carries no reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      idx    <= 4'd0;
      drops  <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (beat) begin
        idx <= pop ? 4'd0 : idx + 4'd1;
      end
      if (drop && drops != 8'hFF) begin
        drops <= drops + 8'd1;
      end
    end
  end

  // Bin k real part sits at field 2k from the MSB end, imaginary just below.
  always_comb begin
    out_r = '0;
    out_i = '0;
    for (int k = 0; k < 11; k++) begin
      if (out_valid && idx == 4'(k)) begin
        out_r = head[(22-2*k)*WL_out-1 -: WL_out];
        out_i = head[(21-2*k)*WL_out-1 -: WL_out];
      end
    end
  end

endmodule
